uart_autobaud: RTL

UART_AUTOBAUD -- requirements
Module: uart_autobaud

---
 rtl/uart_autobaud.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/uart_autobaud.sv
// Auto-baud detector: times four bit-pairs of a 0x55 sync character
// and derives the UART divisor (bit period = baudrate_div + 1 clocks).
module uart_autobaud #(
    parameter logic [15:0] DEFAULT_DIV = 16'd433,
    parameter logic [15:0] MIN_DIV     = 16'd3,
    parameter int          PERIOD_W    = 19
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arm,
    input  logic        abort,
    input  logic        uart_rxd,
    output logic [15:0] baudrate_div,
    output logic        locked,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_IDLE,
        S_WAIT_START,
        S_MEASURE,
        S_CALC,
        S_LOCKED
    } state_t;

    localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;

    state_t              state_q, state_d;
    logic                rxd_s1_q, rxd_s1_d;
    logic                rxd_s2_q, rxd_s2_d;
    logic                rxd_prev_q, rxd_prev_d;
    logic [3:0]          idle_cnt_q, idle_cnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [2:0]          edge_q, edge_d;
    logic [PERIOD_W-1:0] count_q, count_d;
    logic [15:0]         div_q, div_d;
    logic                locked_q, locked_d;
    logic                done_q, done_d;
    logic                error_q, error_d;

    logic                fall;
    logic                busy_w;
    logic [PERIOD_W:0]   cnt_sum;
    logic [PERIOD_W:0]   cnt_div;
    logic [PERIOD_W:0]   cand_wide;
    logic [15:0]         candidate;

    assign fall   = rxd_prev_q & ~rxd_s2_q;
    assign busy_w = (state_q != S_IDLE) && (state_q != S_LOCKED);

    // Eight bit periods, rounded to the nearest single period, minus one.
    assign cnt_sum   = {1'b0, count_q} + (PERIOD_W+1)'(4);
    assign cnt_div   = cnt_sum >> 3;
    assign cand_wide = cnt_div - (PERIOD_W+1)'(1);
    assign candidate = 16'(cand_wide);

    always_comb begin
        state_d    = state_q;
        rxd_s1_d   = uart_rxd;
        rxd_s2_d   = rxd_s1_q;
        rxd_prev_d = rxd_s2_q;
        idle_cnt_d = idle_cnt_q;
        period_d   = period_q;
        edge_d     = edge_q;
        count_d    = count_q;
        div_d      = div_q;
        locked_d   = locked_q;
        done_d     = 1'b0;
        error_d    = 1'b0;

        unique case (state_q)
            S_IDLE, S_LOCKED: begin
                if (arm) begin
                    state_d    = S_WAIT_IDLE;
                    idle_cnt_d = '0;
                end
            end
            S_WAIT_IDLE: begin
                if (!rxd_s2_q) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == 4'd15) begin
                    idle_cnt_d = '0;
                    state_d    = S_WAIT_START;
                end else begin
                    idle_cnt_d = idle_cnt_q + 4'd1;
                end
            end
            S_WAIT_START: begin
                if (fall) begin
                    period_d = '0;
                    edge_d   = '0;
                    state_d  = S_MEASURE;
                end
            end
            S_MEASURE: begin
                period_d = period_q + PERIOD_W'(1);
                if (period_q == PERIOD_MAX) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else if (fall) begin
                    edge_d = edge_q + 3'd1;
                    if (edge_q == 3'd3) begin
                        count_d = period_q + PERIOD_W'(1);
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (candidate >= MIN_DIV) begin
                    div_d    = candidate;
                    locked_d = 1'b1;
                    done_d   = 1'b1;
                    state_d  = S_LOCKED;
                end else begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort only cancels an active measurement and suppresses its result.
        if (abort && busy_w) begin
            state_d  = S_IDLE;
            div_d    = div_q;
            locked_d = locked_q;
            done_d   = 1'b0;
            error_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rxd_s1_q   <= 1'b1;
            rxd_s2_q   <= 1'b1;
            rxd_prev_q <= 1'b1;
            idle_cnt_q <= '0;
            period_q   <= '0;
            edge_q     <= '0;
            count_q    <= '0;
            div_q      <= DEFAULT_DIV;
            locked_q   <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rxd_s1_q   <= rxd_s1_d;
            rxd_s2_q   <= rxd_s2_d;
            rxd_prev_q <= rxd_prev_d;
            idle_cnt_q <= idle_cnt_d;
            period_q   <= period_d;
            edge_q     <= edge_d;
            count_q    <= count_d;
            div_q      <= div_d;
            locked_q   <= locked_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign baudrate_div = div_q;
    assign locked       = locked_q;
    assign busy         = busy_w;
    assign done         = done_q;
    assign error        = error_q;

endmodule
